// File: rtl/life_board_writer.sv
// 16x16 Game of Life board owner: scans one cell per clock into a shadow board,
// then commits the whole generation at once so the pixel reader never sees a partial update.
module life_board_writer #(
    parameter  int ROW_SIZE = 16,
    parameter  int COL_SIZE = 16,
    parameter  int WRAP     = 0,
    localparam int CELLS    = ROW_SIZE * COL_SIZE,
    localparam int IDX_W    = $clog2(CELLS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load_en,
    input  logic [CELLS-1:0] i_load_board,
    input  logic             i_toggle_en,
    input  logic [IDX_W-1:0] i_toggle_idx,
    input  logic             i_step,
    output logic [CELLS-1:0] o_board_out,
    output logic             o_busy,
    output logic             o_done,
    output logic [15:0]      o_gen_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_COMMIT
    } state_t;

    state_t           r_state;
    logic [CELLS-1:0] r_board;
    logic [CELLS-1:0] r_shadow;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy;
    logic             r_done;
    logic [15:0]      r_gen_count;

    logic [3:0]       w_count;
    logic             w_next_cell;

    // Live-neighbour count of the cell at r_idx, read from the committed board.
    always_comb begin
        int row_i;
        int col_i;
        int nr;
        int nc;
        // NOTE: every variable gets a value before any branch, so no latch can be inferred.
        row_i   = int'(r_idx) / ROW_SIZE;
        col_i   = int'(r_idx) % ROW_SIZE;
        nr      = 0;
        nc      = 0;
        w_count = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr != 0 || dc != 0) begin
                    if (WRAP != 0) begin
                        nr      = (row_i + dr + COL_SIZE) % COL_SIZE;
                        nc      = (col_i + dc + ROW_SIZE) % ROW_SIZE;
                        w_count = w_count + 4'(r_board[IDX_W'(nr * ROW_SIZE + nc)]);
                    end else begin
                        nr = row_i + dr;
                        nc = col_i + dc;
                        if (nr >= 0 && nr < COL_SIZE && nc >= 0 && nc < ROW_SIZE) begin
                            w_count = w_count + 4'(r_board[IDX_W'(nr * ROW_SIZE + nc)]);
                        end
                    end
                end
            end
        end
    end

    assign w_next_cell = (w_count == 4'd3) | (r_board[r_idx] & (w_count == 4'd2));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            r_state     <= S_IDLE;
            r_board     <= '0;
            r_shadow    <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_gen_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_load_en) begin
                        r_board     <= i_load_board;
                        r_gen_count <= '0;
                    end else if (i_toggle_en) begin
                        r_board[i_toggle_idx] <= ~r_board[i_toggle_idx];
                    end else if (i_step) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_shadow[r_idx] <= w_next_cell;
                    r_idx           <= r_idx + 1'b1;
                    if (r_idx == IDX_W'(CELLS - 1)) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_board     <= r_shadow;
                    r_gen_count <= r_gen_count + 16'd1;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_board_out = r_board;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_gen_count = r_gen_count;

endmodule

// File: tb/tb_life_board_writer.sv
// Scoreboard bench: drives a WRAP=0 and a WRAP=1 instance with shared stimulus and
// compares each committed generation against an independent Life model.
module tb_life_board_writer;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_en;
    logic [255:0] load_board;
    logic         toggle_en;
    logic [7:0]   toggle_idx;
    logic         step;

    logic [255:0] board0, board1;
    logic         busy0, busy1, done0, done1;
    logic [15:0]  gen0, gen1;

    always #5 clk = ~clk;

    life_board_writer #(.ROW_SIZE(16), .COL_SIZE(16), .WRAP(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_load_en(load_en), .i_load_board(load_board),
        .i_toggle_en(toggle_en), .i_toggle_idx(toggle_idx), .i_step(step),
        .o_board_out(board0), .o_busy(busy0), .o_done(done0), .o_gen_count(gen0)
    );

    life_board_writer #(.ROW_SIZE(16), .COL_SIZE(16), .WRAP(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_load_en(load_en), .i_load_board(load_board),
        .i_toggle_en(toggle_en), .i_toggle_idx(toggle_idx), .i_step(step),
        .o_board_out(board1), .o_busy(busy1), .o_done(done1), .o_gen_count(gen1)
    );

    typedef struct {
        logic [255:0] b0;
        logic [255:0] b1;
        logic [15:0]  gen;
    } exp_t;

    exp_t         sb[$];
    logic [255:0] m_b0, m_b1;
    logic [15:0]  m_gen;
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] set3(input int a, input int b, input int c);
        logic [255:0] v;
        v    = '0;
        v[a] = 1'b1;
        v[b] = 1'b1;
        v[c] = 1'b1;
        return v;
    endfunction

    function automatic logic [255:0] life(input logic [255:0] b, input bit wrap);
        logic [255:0] nb;
        nb = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr;
                        int cc;
                        rr = r + dr;
                        cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrap) begin
                            rr = (rr + 16) % 16;
                            cc = (cc + 16) % 16;
                        end else if (rr < 0 || rr > 15 || cc < 0 || cc > 15) begin
                            continue;
                        end
                        if (b[rr*16 + cc]) n++;
                    end
                end
                nb[r*16 + c] = (n == 3) || (b[r*16 + c] && n == 2);
            end
        end
        return nb;
    endfunction

    task automatic do_load(input logic [255:0] b);
        load_board = b;
        load_en    = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        m_b0    = b;
        m_b1    = b;
        m_gen   = '0;
        check("load_b0", board0, b);
        check("load_gen", gen0, 16'd0);
    endtask

    task automatic do_toggle(input logic [7:0] idx);
        toggle_idx = idx;
        toggle_en  = 1'b1;
        @(negedge clk);
        toggle_en  = 1'b0;
        m_b0[idx]  = ~m_b0[idx];
        m_b1[idx]  = ~m_b1[idx];
        check("toggle_b0", board0, m_b0);
        check("toggle_b1", board1, m_b1);
    endtask

    // One generation; with inject set, load/toggle are pulsed mid-scan and must be ignored.
    task automatic do_step(input bit inject);
        exp_t         e;
        logic [255:0] pre0, pre1;
        int           cyc;
        e.b0  = life(m_b0, 1'b0);
        e.b1  = life(m_b1, 1'b1);
        e.gen = m_gen + 16'd1;
        sb.push_back(e);
        pre0 = board0;
        pre1 = board1;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        cyc  = 1;
        check("busy_on", {busy1, busy0}, 2'b11);
        while (!done0 && cyc < 400) begin
            if (inject && cyc == 100) begin
                load_board = ~m_b0;
                load_en    = 1'b1;
                toggle_idx = 8'd7;
                toggle_en  = 1'b1;
            end else begin
                load_en   = 1'b0;
                toggle_en = 1'b0;
            end
            if (cyc == 129) begin
                check("no_tear_b0", board0, pre0);
                check("no_tear_b1", board1, pre1);
            end
            @(negedge clk);
            cyc++;
        end
        load_en   = 1'b0;
        toggle_en = 1'b0;
        check("latency", 256'(cyc), 256'(258));
        check("done_both", {done1, done0}, 2'b11);
        check("busy_off", {busy1, busy0}, 2'b00);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("gen_b0", board0, e.b0);
            check("gen_b1", board1, e.b1);
            check("gen_cnt0", gen0, e.gen);
            check("gen_cnt1", gen1, e.gen);
            m_b0  = e.b0;
            m_b1  = e.b1;
            m_gen = e.gen;
        end else begin
            check("sb_empty", 256'(sb.size()), 256'(1));
        end
        @(negedge clk);
        check("done_pulse", {done1, done0}, 2'b00);
    endtask

    initial begin
        logic [255:0] pat;
        logic [255:0] block;
        bit           seen;

        rst        = 1'b1;
        load_en    = 1'b0;
        load_board = '0;
        toggle_en  = 1'b0;
        toggle_idx = '0;
        step       = 1'b0;
        m_b0       = '0;
        m_b1       = '0;
        m_gen      = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_board", {board1, board0} != '0, 1'b0);
        check("rst_flags", {busy1, busy0, done1, done0}, 4'b0000);
        check("rst_gen", {gen1, gen0}, 32'd0);

        // Blinker in row 1 turns vertical in column 2.
        do_load(set3(17, 18, 19));
        do_step(1'b0);
        check("blinker_const", board0, set3(2, 18, 34));
        check("blinker_gen", gen0, 16'd1);

        // Block still life in the corner survives three generations.
        block = set3(0, 1, 16) | set3(17, 17, 17);
        do_load(block);
        repeat (3) do_step(1'b0);
        check("block_b0", board0, block);
        check("block_b1", board1, block);
        check("block_gen", gen0, 16'd3);

        // Blinker straddling the left/right edge.
        do_load(set3(15, 0, 1));
        do_step(1'b0);
        check("edge_wrap", board1, set3(240, 0, 16));
        check("edge_nowrap", board0, 256'd0);

        // Load/toggle while busy are dropped.
        do_load(set3(17, 18, 19));
        do_step(1'b1);
        check("busy_reject", board0, set3(2, 18, 34));

        // Load wins over toggle and step in the same cycle.
        pat        = set3(100, 101, 102);
        load_board = pat;
        load_en    = 1'b1;
        toggle_en  = 1'b1;
        toggle_idx = 8'd5;
        step       = 1'b1;
        @(negedge clk);
        load_en   = 1'b0;
        toggle_en = 1'b0;
        step      = 1'b0;
        m_b0      = pat;
        m_b1      = pat;
        m_gen     = '0;
        check("prio_board", board0, pat);
        check("prio_busy", {busy1, busy0}, 2'b00);
        @(negedge clk);
        check("prio_nostep", {busy1, busy0}, 2'b00);
        do_toggle(8'd5);
        check("prio_tog5", board0, pat | (256'd1 << 5));

        // Random soup, two generations against the model.
        for (int i = 0; i < 8; i++) pat[i*32 +: 32] = $urandom;
        do_load(pat);
        repeat (2) do_step(1'b0);

        // Reset in the middle of a scan.
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (127) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_board", {board1, board0} != '0, 1'b0);
        check("mid_rst_flags", {busy1, busy0, done1, done0}, 4'b0000);
        check("mid_rst_gen", {gen1, gen0}, 32'd0);
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (done0 || done1 || busy0 || busy1) seen = 1'b1;
        end
        check("mid_rst_quiet", seen, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
